park_sensor_cond: RTL
=====================

# park_sensor_cond

Upstream conditioning stage for the `park` gate controller. It synchronises and debounces the raw entrance, gate-pass and lot-leave sensors, and drives clean `sensor_entrance` and `sensor_exit` levels into `park`. It also maintains the lot occupancy count, which feeds the full/empty indicators and an optional full-lot entrance lockout.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synced cycles required before a debounced level changes. Legal range 1..255.
- `CAPACITY`, default 8: number of spaces in the lot. Legal range 1..(2^`CNT_W` − 1).
- `CNT_W`, default 4: width of the occupancy counter.

Ports:
- `clk` input 1: single system clock. All logic is on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `raw_entrance` input 1: asynchronous car-at-entrance sensor.
- `raw_exit` input 1: asynchronous car-passed-gate sensor.
- `raw_leave` input 1: asynchronous car-left-lot sensor.
- `sensor_entrance` output 1: debounced entrance level to `park`, subject to full gating (see Configuration).
- `sensor_exit` output 1: debounced gate-pass level to `park`.
- `occupancy` output `CNT_W`: number of cars currently in the lot.
- `lot_full` output 1: high when `occupancy` == `CAPACITY`.
- `lot_empty` output 1: high when `occupancy` == 0.
- `count_err` output 1: one-cycle pulse on an attempted overflow or underflow.

## Operation

- **Synchroniser:** each raw input passes through a 2-flop synchroniser, giving `s1` then `s2`.
- **Debouncer:** one per sensor (entrance, exit, leave). Each has a stable counter of width ceil(log2(`DEBOUNCE_CYCLES`+1)) and a debounced level `db`.
  - When `s2` == `db`, the counter clears to 0.
  - When `s2` != `db`, the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `db` takes `s2` and the counter clears.
  - A glitch that lasts fewer than `DEBOUNCE_CYCLES` synced cycles never reaches `db`.
- **Edge detection:** a registered previous `db` per sensor. A rise is `db & ~db_prev`.
- **Occupancy update:** `occupancy` changes on the cycle after a debounced rise.
  - Exit rise only, with `occupancy` < `CAPACITY`: increment.
  - Exit rise only, with `occupancy` == `CAPACITY`: hold and pulse `count_err`.
  - Leave rise only, with `occupancy` > 0: decrement.
  - Leave rise only, with `occupancy` == 0: hold and pulse `count_err`.
  - Exit rise and leave rise in the same cycle: `occupancy` unchanged, no `count_err`, whatever the count.
- **Status flags:** `lot_full` and `lot_empty` are combinational compares on the registered `occupancy`. Arithmetic is unsigned `CNT_W`-bit and never wraps.
- **Reset values:** `reset_n` low at a clock edge clears everything the same cycle. This covers all synchroniser flops, `db`, `db_prev`, counters and `occupancy`.
  - After reset: `sensor_entrance` = 0, `sensor_exit` = 0, `occupancy` = 0, `lot_full` = 0, `lot_empty` = 1, `count_err` = 0.
  - A reset mid-debounce discards the partial count. A sensor still held high after release must debounce again from scratch.

## Timing

- **Debounce latency:** suppose a raw level first sampled at edge k stays stable. Then `db` and the sensor output change after edge k+1+`DEBOUNCE_CYCLES`, which is `DEBOUNCE_CYCLES`+2 edges in total (6 at the default).
- **Occupancy latency:** `occupancy` and `count_err` update one edge after the debounced rise, i.e. `DEBOUNCE_CYCLES`+3 edges after the raw rise. `lot_full` and `lot_empty` follow in the same cycle.
- **Count-once rule:** a held-high sensor counts exactly once. It counts again only after a debounced fall followed by a new debounced rise.

## Configuration

- **`PARK_FULL_GATE_EN` defined:** `sensor_entrance` = `db_entrance & ~lot_full`.
  - While the lot is full, `park` never sees an entrance request.
  - If the lot becomes full while `db_entrance` is high, `sensor_entrance` drops in the same cycle as `lot_full` rises.
  - It reasserts in the cycle `lot_full` falls, provided `db_entrance` is still high.
- **`PARK_FULL_GATE_EN` undefined:** `sensor_entrance` = `db_entrance` unconditionally. `lot_full` is informational only.

## Test plan

- **Reset:** hold `reset_n` = 0 for 2 cycles with all raw inputs at 1, then release. Required: all outputs are at reset values during reset; `sensor_entrance` rises exactly 6 edges after release (defaults).
- **Glitch rejection:** pulse `raw_exit` high for 3 cycles, then 0. Required: `sensor_exit` stays 0 and `occupancy` stays 0. Then hold `raw_exit` high for 10 cycles. Required: `sensor_exit` rises after 6 edges and `occupancy` = 1 one edge later.
- **Fill to capacity:** use `CAPACITY` = 2. Apply three debounced `raw_exit` high/low pairs. Required: `occupancy` steps 1, 2, 2; `lot_full` = 1 after the second; `count_err` pulses exactly once on the third.
- **Underflow and simultaneous events:** from `occupancy` = 0, one debounced `raw_leave` pulse. Required: `count_err` pulses and `occupancy` = 0. Then from `occupancy` = 1, raise `raw_exit` and `raw_leave` on the same edge. Required: `occupancy` stays 1 and `count_err` stays 0.
- **Full gating:** with `PARK_FULL_GATE_EN` defined and `occupancy` = `CAPACITY`, hold `raw_entrance` high. Required: `sensor_entrance` = 0; one leave event makes it 1 in the cycle `lot_full` falls. Without the macro, the same stimulus gives `sensor_entrance` = 1 throughout.
- **Reset mid-operation:** assert `reset_n` = 0 for 1 cycle at debounce count 3 with `occupancy` = 5. Required: `occupancy` = 0, `lot_empty` = 1, and the held sensor needs a full 6 edges to reassert.

Source files
------------

// File: rtl/park_sensor_cond.sv
// Sensor conditioning for the park gate controller: sync, debounce, rise detect, occupancy count.
// Optional full-lot entrance lockout enabled by defining PARK_FULL_GATE_EN.
module park_sensor_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CAPACITY        = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  input  logic             raw_leave,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             count_err
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IX_EN = 0;
  localparam int unsigned IX_EX = 1;
  localparam int unsigned IX_LV = 2;

  logic [2:0]      s1, s2, db, db_prev;
  logic [DB_W-1:0] stab [3];
  logic [2:0]      rise;

  assign rise = db & ~db_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1        <= '0;
      s2        <= '0;
      db        <= '0;
      db_prev   <= '0;
      occupancy <= '0;
      count_err <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) stab[i] <= '0;
    end else begin
      s1      <= {raw_leave, raw_exit, raw_entrance};
      s2      <= s1;
      db_prev <= db;
      // Flip on the edge the counter would reach DEBOUNCE_CYCLES, so compare against one less.
      for (int unsigned i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]   <= s2[i];
          stab[i] <= '0;
        end else begin
          stab[i] <= stab[i] + DB_W'(1);
        end
      end

      count_err <= 1'b0;
      if (rise[IX_EX] && !rise[IX_LV]) begin
        if (occupancy < CNT_W'(CAPACITY)) occupancy <= occupancy + CNT_W'(1);
        else                               count_err <= 1'b1;
      end else if (rise[IX_LV] && !rise[IX_EX]) begin
        if (occupancy != '0) occupancy <= occupancy - CNT_W'(1);
        else                 count_err <= 1'b1;
      end
    end
  end

  assign lot_full    = (occupancy == CNT_W'(CAPACITY));
  assign lot_empty   = (occupancy == '0);
  assign sensor_exit = db[IX_EX];

`ifdef PARK_FULL_GATE_EN
  assign sensor_entrance = db[IX_EN] & ~lot_full;
`else
  assign sensor_entrance = db[IX_EN];
`endif

endmodule
